// File: rtl/bcd3_to_bin.sv
// Sequential 3-digit BCD (+ thousands carry) to 11-bit binary converter, reverse double-dabble.
// Optional invalid-digit detection enabled by defining BCD2BIN_ERR_EN.
module bcd3_to_bin (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [11:0] bcd,
  input  logic        bcd_carry,
  output logic        busy,
  output logic        done,
  output logic [10:0] bin,
  output logic        err
);

  // state   | meaning
  // S_IDLE  | waiting for start; outputs hold last result
  // S_SHIFT | one shift-and-correct step per cycle, cnt 0..10
  typedef enum logic {S_IDLE, S_SHIFT} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [12:0] sr_q, sr_d;
  logic [10:0] acc_q, acc_d;
  logic [10:0] bin_q, bin_d;
  logic        done_q, done_d;

  logic [12:0] sh_sr;
  logic [10:0] sh_acc;
  logic [12:0] fix_sr;

  function automatic logic [3:0] dab_fix(input logic [3:0] d);
    return (d >= 4'd8) ? (d - 4'd3) : d;
  endfunction

`ifdef BCD2BIN_ERR_EN
  logic err_q, err_d;
  logic bad_digit;
  assign bad_digit = (bcd[11:8] > 4'd9) || (bcd[7:4] > 4'd9) || (bcd[3:0] > 4'd9);
`endif

  always_comb begin
    sh_sr  = {1'b0, sr_q[12:1]};
    sh_acc = {sr_q[0], acc_q[10:1]};
    fix_sr = {sh_sr[12], dab_fix(sh_sr[11:8]), dab_fix(sh_sr[7:4]), dab_fix(sh_sr[3:0])};

    state_d = state_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    acc_d   = acc_q;
    bin_d   = bin_q;
    done_d  = 1'b0;
`ifdef BCD2BIN_ERR_EN
    err_d   = err_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (start) begin
`ifdef BCD2BIN_ERR_EN
          if (bad_digit) begin
            done_d = 1'b1;
            err_d  = 1'b1;
            bin_d  = '0;
          end else begin
            sr_d    = {bcd_carry, bcd};
            acc_d   = '0;
            cnt_d   = '0;
            state_d = S_SHIFT;
          end
`else
          sr_d    = {bcd_carry, bcd};
          acc_d   = '0;
          cnt_d   = '0;
          state_d = S_SHIFT;
`endif
        end
      end
      S_SHIFT: begin
        sr_d  = fix_sr;
        acc_d = sh_acc;
        cnt_d = cnt_q + 4'd1;
        // 11th shift completes the binary word
        if (cnt_q == 4'd10) begin
          bin_d   = sh_acc;
          done_d  = 1'b1;
          cnt_d   = '0;
          state_d = S_IDLE;
`ifdef BCD2BIN_ERR_EN
          err_d   = 1'b0;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      sr_q    <= '0;
      acc_q   <= '0;
      bin_q   <= '0;
      done_q  <= 1'b0;
`ifdef BCD2BIN_ERR_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      acc_q   <= acc_d;
      bin_q   <= bin_d;
      done_q  <= done_d;
`ifdef BCD2BIN_ERR_EN
      err_q   <= err_d;
`endif
    end
  end

  assign busy = (state_q == S_SHIFT);
  assign done = done_q;
  assign bin  = bin_q;
`ifdef BCD2BIN_ERR_EN
  assign err  = err_q;
`else
  assign err  = 1'b0;
`endif

endmodule

// File: tb/tb_bcd3_to_bin.sv
// Directed self-checking bench for bcd3_to_bin; follows BCD2BIN_ERR_EN like the design.
module tb_bcd3_to_bin;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [11:0] bcd;
  logic        bcd_carry;
  logic        busy;
  logic        done;
  logic [10:0] bin;
  logic        err;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  bcd3_to_bin dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .bcd      (bcd),
    .bcd_carry(bcd_carry),
    .busy     (busy),
    .done     (done),
    .bin      (bin),
    .err      (err)
  );

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // exp_lat: edges after the accept edge until done is visible
  task automatic run_conv(input string tag, input logic [11:0] b, input logic c,
                          input logic [10:0] exp_bin, input logic exp_err,
                          input int exp_lat, input bit check_bin);
    int lat;
    int busy_n;
    @(negedge clk);
    bcd = b; bcd_carry = c; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk_eq({tag, "_busy_t0"}, busy, (exp_lat != 0));
    lat = 0;
    busy_n = busy ? 1 : 0;
    while (!done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (busy) busy_n++;
    end
    chk_eq({tag, "_lat"}, lat, exp_lat);
    chk_eq({tag, "_busy_cycles"}, busy_n, exp_lat);
    chk_eq({tag, "_busy_at_done"}, busy, 0);
    if (check_bin) chk_eq({tag, "_bin"}, bin, exp_bin);
    chk_eq({tag, "_err"}, err, exp_err);
    @(posedge clk); #1;
    chk_eq({tag, "_done_pulse"}, done, 0);
    if (check_bin) chk_eq({tag, "_bin_hold"}, bin, exp_bin);
  endtask

  initial begin
    int ndone;
    int gap;
    rst_n = 1'b0; start = 1'b0; bcd = '0; bcd_carry = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_eq("rst_busy", busy, 0);
    chk_eq("rst_done", done, 0);
    chk_eq("rst_bin", bin, 0);
    chk_eq("rst_err", err, 0);
    @(negedge clk); rst_n = 1'b1;

    run_conv("c999", 12'h999, 1'b0, 11'd999, 1'b0, 11, 1'b1);
    run_conv("c1999", 12'h999, 1'b1, 11'd1999, 1'b0, 11, 1'b1);
    run_conv("c0", 12'h000, 1'b0, 11'd0, 1'b0, 11, 1'b1);
    run_conv("c512", 12'h512, 1'b0, 11'd512, 1'b0, 11, 1'b1);
    run_conv("c1087", 12'h087, 1'b1, 11'd1087, 1'b0, 11, 1'b1);

    // start pulse mid-conversion is ignored
    @(negedge clk); bcd = 12'h123; bcd_carry = 1'b0; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk); bcd = 12'h456; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    ndone = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (done) begin
        ndone++;
        chk_eq("ign_bin_at_done", bin, 123);
      end
    end
    chk_eq("ign_done_count", ndone, 1);
    chk_eq("ign_bin", bin, 123);

    // start held: back-to-back conversions
    @(negedge clk); bcd = 12'h123; start = 1'b1;
    @(posedge clk); #1;
    bcd = 12'h456;
    gap = 0;
    while (!done && gap < 40) begin @(posedge clk); #1; gap++; end
    chk_eq("held_lat1", gap, 11);
    chk_eq("held_bin1", bin, 123);
    gap = 0;
    @(posedge clk); #1;
    gap++;
    chk_eq("held_busy_reaccept", busy, 1);
    start = 1'b0;
    while (!done && gap < 40) begin @(posedge clk); #1; gap++; end
    chk_eq("held_gap", gap, 12);
    chk_eq("held_bin2", bin, 456);

    // reset mid-conversion
    @(negedge clk); bcd = 12'h777; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk); rst_n = 1'b0;
    @(posedge clk); #1;
    chk_eq("mrst_busy", busy, 0);
    chk_eq("mrst_done", done, 0);
    chk_eq("mrst_bin", bin, 0);
    chk_eq("mrst_err", err, 0);
    @(negedge clk); rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (done || busy) ndone++;
    end
    chk_eq("mrst_quiet", ndone, 0);
    run_conv("c42", 12'h042, 1'b0, 11'd42, 1'b0, 11, 1'b1);

`ifdef BCD2BIN_ERR_EN
    run_conv("bad9a5", 12'h9A5, 1'b0, 11'd0, 1'b1, 0, 1'b1);
    run_conv("c100", 12'h100, 1'b0, 11'd100, 1'b0, 11, 1'b1);
`else
    run_conv("bad9a5", 12'h9A5, 1'b0, 11'd0, 1'b0, 11, 1'b0);
    run_conv("c100", 12'h100, 1'b0, 11'd100, 1'b0, 11, 1'b1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
